fp_addsub_seq: RTL

Sequencer for the double-precision add/subtract datapath. It accepts one operation at a time over a valid/ready handshake and latches the operands and mode. It then steps the datapath through its stages by driving the `state` code that the compare/align and add stages decode, and returns the result over a second valid/ready handshake. It sits between the FPU command interface and the compare/align → add → normalize pipeline, and is the only driver of that pipeline's `state`, `mode`, `operand_1` and `operand_2` inputs.

---
 rtl/fp_addsub_seq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fp_addsub_seq.sv
// Handshake sequencer for the double-precision add/sub datapath.
// Drives the stage code and latched operands; returns result or error.
module fp_addsub_seq #(
   parameter int NORM_MAX = 56,
   parameter int CNT_W    = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_op1,
   input  logic [63:0] in_op2,
   input  logic [2:0]  in_mode,
   output logic [63:0] operand_1,
   output logic [63:0] operand_2,
   output logic [2:0]  mode,
   output logic [3:0]  state,
   input  logic        norm_done,
   input  logic [63:0] dp_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_result,
   output logic        out_err,
   output logic        busy
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_COMP = 4'd1,
      S_ADD  = 4'd2,
      S_NORM = 4'd3,
      S_DONE = 4'd4
   } state_t;

   localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NORM_MAX);

   state_t           state_q, state_d;
   logic [63:0]      op1_q, op1_d;
   logic [63:0]      op2_q, op2_d;
   logic [2:0]       mode_q, mode_d;
   logic [63:0]      res_q, res_d;
   logic             err_q, err_d;
   logic             vld_q, vld_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign in_ready   = (state_q == S_IDLE) && !flush;
   assign busy       = (state_q != S_IDLE);
   assign state      = state_q;
   assign operand_1  = op1_q;
   assign operand_2  = op2_q;
   assign mode       = mode_q;
   assign out_valid  = vld_q;
   assign out_result = res_q;
   assign out_err    = err_q;

   always_comb begin
      state_d = state_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      mode_d  = mode_q;
      res_d   = res_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      if (flush) begin
         state_d = S_IDLE;
         err_d   = 1'b0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  op1_d  = in_op1;
                  op2_d  = in_op2;
                  mode_d = in_mode;
                  // modes with bit 1 set (2,3,6,7) are illegal
                  if (in_mode[1]) begin
                     state_d = S_DONE;
                     res_d   = '0;
                     err_d   = 1'b1;
                  end else begin
                     state_d = S_COMP;
                  end
               end
            end
            S_COMP: state_d = S_ADD;
            S_ADD: begin
               state_d = S_NORM;
               cnt_d   = CNT_W'(1);
            end
            S_NORM: begin
               if (norm_done) begin
                  state_d = S_DONE;
                  res_d   = dp_result;
                  err_d   = 1'b0;
               end else if (cnt_q == CNT_MAX) begin
                  state_d = S_DONE;
                  res_d   = QNAN;
                  err_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_DONE: begin
               if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
      vld_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op1_q   <= '0;
         op2_q   <= '0;
         mode_q  <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         vld_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         mode_q  <= mode_d;
         res_q   <= res_d;
         err_q   <= err_d;
         vld_q   <= vld_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
